// File: rtl/instructions_loader.sv
// instructions_loader: receives a framed program image (SYNC, ADDR, LEN,
// data bytes, CHK) over a valid/ready byte stream and writes it into the
// instruction memory write port, stalling the CPU while a frame is loaded.
module instructions_loader #(
  parameter int unsigned TIMEOUT = 1000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       mem_we,
  output logic [7:0] mem_endereco,
  output logic [7:0] mem_dado,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       erro
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] idle_q, idle_d;
  logic        ready_q;
  logic        we_q, we_d;
  logic [7:0]  maddr_q, maddr_d;
  logic [7:0]  mdata_q, mdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        erro_q, erro_d;

  logic        xfer;
  logic [31:0] idle_inc;
  logic        timeout_hit;
  logic [7:0]  chk_sum;

  assign xfer     = byte_valid && ready_q;
  assign idle_inc = idle_q + 32'd1;
  assign chk_sum  = sum_q + byte_in;

  // Fires on the edge where the idle count would reach TIMEOUT; a transfer
  // in that same cycle always wins.
  assign timeout_hit = (TIMEOUT != 0) && (state_q != S_IDLE) && !xfer &&
                       (idle_inc == TIMEOUT);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: advance one field per accepted byte, abort on timeout.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (xfer) begin
      case (state_q)
        S_IDLE: if (byte_in == SYNC) state_d = S_ADDR;
        S_ADDR: state_d = S_LEN;
        S_LEN:  state_d = S_DATA;
        S_DATA: if (cnt_q == 9'd1) state_d = S_CHK;
        S_CHK:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    idle_d  = '0;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    erro_d  = erro_q;

    if ((state_q != S_IDLE) && !xfer && (TIMEOUT != 0)) idle_d = idle_inc;

    if (timeout_hit) begin
      idle_d = '0;
      erro_d = 1'b1;
    end

    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (byte_in == SYNC) begin
            hold_d = 1'b1;
            erro_d = 1'b0;
            sum_d  = '0;
          end
        end
        S_ADDR: begin
          addr_d = byte_in;
          sum_d  = byte_in;
        end
        S_LEN: begin
          cnt_d = (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
          sum_d = chk_sum;
        end
        S_DATA: begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          mdata_d = byte_in;
          addr_d  = addr_q + 8'd1;
          cnt_d   = cnt_q - 9'd1;
          sum_d   = chk_sum;
        end
        S_CHK: begin
          sum_d = chk_sum;
          if (chk_sum == 8'h00) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            erro_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      ready_q <= 1'b1;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
    end
  end

  assign byte_ready   = ready_q;
  assign mem_we       = we_q;
  assign mem_endereco = maddr_q;
  assign mem_dado     = mdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign erro         = erro_q;

endmodule

// File: tb/tb_instructions_loader.sv
// Testbench for instructions_loader: table of per-cycle byte inputs with
// expected outputs, plus directed sequences for the 256-byte frame and
// mid-frame reset.
module tb_instructions_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_endereco;
  logic [7:0] mem_dado;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       erro;

  instructions_loader #(.TIMEOUT(4), .SYNC(8'hA5)) dut (
    .clock        (clock),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .erro         (erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic       hold;
    logic       bsy;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic v, logic [7:0] b, logic we, logic [7:0] a,
                              logic [7:0] d, logic hold, logic bsy, logic dn,
                              logic er);
    vec_t r;
    r.v = v; r.b = b; r.we = we; r.a = a; r.d = d;
    r.hold = hold; r.bsy = bsy; r.dn = dn; r.er = er;
    return r;
  endfunction

  // {ready, we, addr, data, hold, busy, done, erro}
  function automatic logic [21:0] obs();
    return {byte_ready, mem_we, mem_endereco, mem_dado, cpu_hold, busy, done, erro};
  endfunction

  function automatic logic [21:0] ev(logic r, logic we, logic [7:0] a, logic [7:0] d,
                                     logic h, logic b, logic dn, logic e);
    return {r, we, a, d, h, b, dn, e};
  endfunction

  task automatic chk(string name, logic [21:0] got, logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (ready,we,addr,data,hold,busy,done,erro)",
               name, got, exp);
    end
  endtask

  // Drive one cycle of input; returns at the following negedge, after the
  // posedge that consumed it.
  task automatic step(logic v, logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] db;
    logic [7:0] exp_a;
    int         writes;

    // Frame A: 0A+03+08+10+17 = 3C, so CHK = C4
    tbl.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hA5, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h0A, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h08, 1, 8'h0A, 8'h08, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h10, 1, 8'h0B, 8'h10, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h17, 1, 8'h0C, 8'h17, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'hC4, 0, 8'h0C, 8'h17, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h0C, 8'h17, 0, 0, 0, 0));
    // Address wrap FE, FF, 00
    tbl.push_back(mk(1, 8'hA5, 0, 8'h0C, 8'h17, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'hFE, 0, 8'h0C, 8'h17, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 8'h0C, 8'h17, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h11, 1, 8'hFE, 8'h11, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h22, 1, 8'hFF, 8'h22, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 1, 8'h00, 8'h33, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h99, 0, 8'h00, 8'h33, 0, 0, 1, 0));
    // Bad checksum
    tbl.push_back(mk(1, 8'hA5, 0, 8'h00, 8'h33, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h10, 0, 8'h00, 8'h33, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 8'h00, 8'h33, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 1, 8'h10, 8'h55, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h10, 8'h55, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h10, 8'h55, 1, 0, 0, 1));
    // Good frame with SYNC as data: 30+01+A5 = D6, CHK = 2A
    tbl.push_back(mk(1, 8'hA5, 0, 8'h10, 8'h55, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h30, 0, 8'h10, 8'h55, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 8'h10, 8'h55, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 1, 8'h30, 8'hA5, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h2A, 0, 8'h30, 8'hA5, 0, 0, 1, 0));
    // Back-to-back SYNC, then timeout after one data byte
    tbl.push_back(mk(1, 8'hA5, 0, 8'h30, 8'hA5, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h20, 0, 8'h30, 8'hA5, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 8'h30, 8'hA5, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 1, 8'h20, 8'hAA, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h20, 8'hAA, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h20, 8'hAA, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h20, 8'hAA, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h20, 8'hAA, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h20, 8'hAA, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 8'h20, 8'hAA, 1, 0, 0, 1));

    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clock);
    chk("reset_outputs", obs(), '0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", obs(), ev(1, 0, 8'h00, 8'h00, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].b);
      chk($sformatf("vec%0d", i), obs(),
          ev(1, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].hold, tbl[i].bsy,
             tbl[i].dn, tbl[i].er));
    end

    // LEN = 00: 256 data bytes starting at C0
    step(1, 8'hA5);
    chk("len0_sync", obs(), ev(1, 0, 8'h20, 8'hAA, 1, 1, 0, 0));
    step(1, 8'hC0);
    step(1, 8'h00);
    sum    = 8'hC0;
    writes = 0;
    for (int i = 0; i < 256; i++) begin
      db    = 8'(i) ^ 8'h5A;
      exp_a = 8'hC0 + 8'(i);
      sum   = sum + db;
      step(1, db);
      if (mem_we === 1'b1) writes++;
      chk($sformatf("len0_data%0d", i), obs(), ev(1, 1, exp_a, db, 1, 1, 0, 0));
    end
    step(1, 8'h00 - sum);
    chk("len0_done", obs(), ev(1, 0, 8'hBF, 8'h5A ^ 8'hFF, 0, 0, 1, 0));
    step(0, 8'h00);
    chk("len0_done_one_cycle", obs(), ev(1, 0, 8'hBF, 8'h5A ^ 8'hFF, 0, 0, 0, 0));
    chk("len0_write_count", 22'(writes), 22'd256);

    // Reset in the middle of the data phase
    step(1, 8'hA5);
    step(1, 8'h10);
    step(1, 8'h00);
    step(1, 8'h11);
    step(1, 8'h22);
    chk("midreset_pre", obs(), ev(1, 1, 8'h11, 8'h22, 1, 1, 0, 0));
    reset = 1'b1;
    step(1, 8'h33);
    chk("midreset_outputs", obs(), '0);
    reset = 1'b0;
    step(0, 8'h00);
    chk("midreset_release", obs(), ev(1, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    step(1, 8'h44);
    chk("midreset_idle_discard", obs(), ev(1, 0, 8'h00, 8'h00, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
